bit_serializer: RTL and testbench
=================================

// Module: bit_serializer
// PURPOSE
//   Parallel-to-serial converter feeding the serial pattern detector's 1-bit din input.
//   Accepts WIDTH-bit words over a valid/ready handshake and emits one bit per clk on sdout.
//   Supports back-to-back words with no idle gap, so patterns that span word boundaries stay detectable.
//   Sits between the word source (control logic/test harness) and the detector.
// PARAMETERS
//   WIDTH       8     word width in bits; legal range 2..32
//   MSB_FIRST   1     1: shift data_in[WIDTH-1] first; 0: shift data_in[0] first
//   IDLE_LEVEL  1'b0  sdout level whenever no word is being shifted
// PORTS
//   clk         in   1      clock, rising edge
//   clr         in   1      reset, asynchronous, active-low
//   data_in     in   WIDTH  word to serialize; sampled only on an accept
//   load_valid  in   1      source offers data_in this cycle
//   load_ready  out  1      serializer can accept this cycle
//   sdout       out  1      serial bit stream; connects to the detector's din
//   bit_valid   out  1      sdout carries a data bit, not idle fill
//   last_bit    out  1      sdout carries the final bit of the current word
//   busy        out  1      state == SHIFT
// BEHAVIOUR
//   Reset (clr=0, async): state=IDLE, shift reg=0, bit count=0, sdout=IDLE_LEVEL.
//     During reset bit_valid=0, last_bit=0, busy=0, load_ready=0 (gated by clr).
//     Reset mid-word discards the word with no partial output.
//   Accept = load_valid & load_ready, sampled at the rising edge.
//   FSM states: IDLE, SHIFT.
//     IDLE:  load_ready=1. Accept -> SHIFT, load the shift reg, count=WIDTH-1. No accept -> stay IDLE.
//     SHIFT: sdout=current head bit, bit_valid=1. Each clk advances one bit and decrements count.
//       While count==0 (last bit): last_bit=1 and load_ready=1.
//         Accept at that edge -> reload and stay in SHIFT; the next word's first bit follows with zero gap.
//         No accept -> IDLE.
//       While count!=0: load_ready=0. load_valid is ignored.
//   Latency: first bit on sdout in the cycle after the accept edge. A word takes exactly WIDTH cycles.
//   All outputs are registered or decoded from registers only. There is no combinational path from load_valid/data_in.
//   load_ready depends on state/count only, never on load_valid.
//   Bit count is $clog2(WIDTH) bits wide. The shift register shifts in IDLE_LEVEL, so the vacated end is never X.
//   In IDLE: sdout=IDLE_LEVEL, bit_valid=0, last_bit=0.
//   data_in changes while not accepting have no effect.
// STRUCTURE
//   Shared package sap1_serial_pkg holds:
//     - state typedef enum logic {IDLE, SHIFT}
//     - localparam SER_IDLE_LEVEL default
//   Single module with no sub-module. State reg, shift reg and counter live in one clocked block; the output decode is combinational.
// TESTING (WIDTH=8, MSB_FIRST=1 unless noted)
//   1. Reset, then accept 8'hD0 -> sdout 1,1,0,1,0,0,0,0 on cycles 1..8; last_bit only on cycle 8; attached detector dout=1 on cycle 5.
//   2. load_valid held high with words 8'hAA, 8'h55 -> 16 contiguous bit_valid cycles; load_ready high only on cycles 8 and 16.
//   3. MSB_FIRST=0, accept 8'h0B -> sdout 1,1,0,1,0,0,0,0.
//   4. Words 8'h03 then 8'h40 back-to-back -> pattern 1101 spans the boundary; detector dout=1 on cycle 11.
//   5. clr pulsed low at cycle 4 of 8'hFF -> sdout=IDLE_LEVEL and busy=0 immediately; load_ready=1 after clr releases; no stray bits.
//   6. load_valid toggled mid-word with data_in changing -> output stream unchanged; no accept until last_bit.

Source files
------------

// File: rtl/sap1_serial_pkg.sv
// Shared types for the serial front end of the pattern detector path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sap1_serial_pkg;

  // Serializer control state: IDLE waits for a word, SHIFT streams it out.
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_t;

  // Line level driven on sdout whenever no data bit is being shifted.
  localparam logic SER_IDLE_LEVEL = 1'b0;

endpackage

// File: rtl/bit_serializer.sv
// Parallel-to-serial converter: WIDTH-bit words in, one bit per clk out on sdout.
// Latency: first bit one cycle after the accept edge; a word occupies exactly WIDTH cycles.
// Backpressure: load_ready only in IDLE or on the last bit of a word; back-to-back words leave no gap.
//
// Ports:
//   clk, clr              clock (rising edge), asynchronous active-low reset
//   data_in, load_valid   word offered by the source; taken when load_valid & load_ready
//   load_ready            decoded from state/count only (and gated low while clr is asserted)
//   sdout                 serial bit stream (IDLE_LEVEL when no word is in flight)
//   bit_valid, last_bit   sdout carries a data bit / the final bit of the current word
//   busy                  serializer is in SHIFT
module bit_serializer
  import sap1_serial_pkg::*;
#(
  parameter int   WIDTH      = 8,              // legal range 2..32
  parameter int   MSB_FIRST  = 1,              // 1: data_in[WIDTH-1] first, 0: data_in[0] first
  parameter logic IDLE_LEVEL = SER_IDLE_LEVEL
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             sdout,
  output logic             bit_valid,
  output logic             last_bit,
  output logic             busy
);

  localparam int             CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

  ser_state_t       state, state_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;

  logic             accept;
  logic             head_bit;
  logic [WIDTH-1:0] shreg_adv;

  // The head bit sits at the end that leaves first; the vacated end is
  // refilled with IDLE_LEVEL so the register never carries stale data.
  always_comb begin
    if (MSB_FIRST != 0) begin
      head_bit  = shreg[WIDTH-1];
      shreg_adv = {shreg[WIDTH-2:0], IDLE_LEVEL};
    end else begin
      head_bit  = shreg[0];
      shreg_adv = {IDLE_LEVEL, shreg[WIDTH-1:1]};
    end
  end

  // load_ready is a pure decode of registered state, so accept never forms a
  // combinational loop back through the source's valid logic.
  assign accept = load_valid & load_ready;

  always_comb begin
    state_nxt = state;
    shreg_nxt = shreg;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = SHIFT;
          shreg_nxt = data_in;
          cnt_nxt   = CNT_LAST;
        end
      end
      SHIFT: begin
        if (cnt == '0) begin
          // Last bit on the line: a new word may be chained here with no gap.
          if (accept) begin
            shreg_nxt = data_in;
            cnt_nxt   = CNT_LAST;
          end else begin
            state_nxt = IDLE;
            shreg_nxt = shreg_adv;
            cnt_nxt   = '0;
          end
        end else begin
          shreg_nxt = shreg_adv;
          cnt_nxt   = cnt - CW'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        shreg_nxt = '0;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state <= IDLE;
      shreg <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      shreg <= shreg_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Output decode from registers only; clr gates load_ready so nothing is
  // accepted while the block is held in reset.
  always_comb begin
    sdout      = IDLE_LEVEL;
    bit_valid  = 1'b0;
    last_bit   = 1'b0;
    busy       = 1'b0;
    load_ready = 1'b0;
    if (state == SHIFT) begin
      sdout      = head_bit;
      bit_valid  = 1'b1;
      busy       = 1'b1;
      last_bit   = (cnt == '0);
      load_ready = clr & (cnt == '0);
    end else begin
      load_ready = clr;
    end
  end

endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer: an MSB-first and an LSB-first instance,
// a bit-level scoreboard per instance, and a 1101 detector model on the MSB stream.
module tb_bit_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       clr;
  logic [7:0] data_in, data_in_l;
  logic       load_valid, load_valid_l;
  logic       load_ready, sdout, bit_valid, last_bit, busy;
  logic       load_ready_l, sdout_l, bit_valid_l, last_bit_l, busy_l;

  int checks = 0;
  int errors = 0;

  // Scoreboard entries: {expected bit, expected last flag}
  logic [1:0] q_m[$];
  logic [1:0] q_l[$];
  logic [1:0] e_m, e_l;
  logic [7:0] s;

  logic [3:0] hist;
  logic       det;

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1), .IDLE_LEVEL(1'b0)) u_msb (
    .clk(clk), .clr(clr), .data_in(data_in), .load_valid(load_valid),
    .load_ready(load_ready), .sdout(sdout), .bit_valid(bit_valid),
    .last_bit(last_bit), .busy(busy)
  );

  bit_serializer #(.WIDTH(8), .MSB_FIRST(0), .IDLE_LEVEL(1'b0)) u_lsb (
    .clk(clk), .clr(clr), .data_in(data_in_l), .load_valid(load_valid_l),
    .load_ready(load_ready_l), .sdout(sdout_l), .bit_valid(bit_valid_l),
    .last_bit(last_bit_l), .busy(busy_l)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic push_word(input logic [7:0] w, input bit msb);
    for (int i = 0; i < 8; i++) begin
      if (msb) q_m.push_back({w[7-i], (i == 7)});
      else     q_l.push_back({w[i],   (i == 7)});
    end
  endtask

  // Registered 1101 detector on the MSB-first stream (overlapping, Moore).
  always @(posedge clk or negedge clr) begin
    if (!clr) begin
      hist <= 4'b0;
      det  <= 1'b0;
    end else begin
      hist <= {hist[2:0], sdout};
      det  <= ({hist[2:0], sdout} == 4'b1101);
    end
  end

  always @(negedge clk) begin
    if (bit_valid) begin
      if (q_m.size() == 0) chk("m_stray_bit", bit_valid, 1'b0);
      else begin
        e_m = q_m.pop_front();
        chk("m_sdout", sdout, e_m[1]);
        chk("m_last",  last_bit, e_m[0]);
      end
    end else begin
      chk("m_idle_sdout", sdout, 1'b0);
      chk("m_idle_last",  last_bit, 1'b0);
    end
  end

  always @(negedge clk) begin
    if (bit_valid_l) begin
      if (q_l.size() == 0) chk("l_stray_bit", bit_valid_l, 1'b0);
      else begin
        e_l = q_l.pop_front();
        chk("l_sdout", sdout_l, e_l[1]);
        chk("l_last",  last_bit_l, e_l[0]);
      end
    end else begin
      chk("l_idle_sdout", sdout_l, 1'b0);
      chk("l_idle_last",  last_bit_l, 1'b0);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    clr = 1'b0; load_valid = 1'b0; load_valid_l = 1'b0;
    data_in = 8'h00; data_in_l = 8'h00; s = 8'h00;
    tick(); tick();

    // Reset state
    mid();
    chk("rst_sdout", sdout, 1'b0);
    chk("rst_bit_valid", bit_valid, 1'b0);
    chk("rst_last", last_bit, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ready", load_ready, 1'b0);
    chk("rst_ready_l", load_ready_l, 1'b0);
    tick();
    clr = 1'b1;
    mid();
    chk("idle_ready", load_ready, 1'b1);

    // 1: single word 8'hD0, MSB first
    tick();
    data_in = 8'hD0; load_valid = 1'b1; push_word(8'hD0, 1'b1);
    tick();
    load_valid = 1'b0; data_in = 8'hFF;
    for (int k = 1; k <= 8; k++) begin
      mid();
      s[8-k] = sdout;
      chk("t1_busy", busy, 1'b1);
      chk("t1_ready", load_ready, (k == 8));
      chk("t1_det", det, (k == 5));
      tick();
    end
    mid();
    chk("t1_stream", s, 8'hD0);
    chk("t1_idle_busy", busy, 1'b0);

    // 2: load_valid held high, 8'hAA then 8'h55 back-to-back
    tick();
    data_in = 8'hAA; load_valid = 1'b1; push_word(8'hAA, 1'b1);
    tick();
    data_in = 8'h55; push_word(8'h55, 1'b1);
    for (int k = 1; k <= 16; k++) begin
      if (k == 16) load_valid = 1'b0;
      mid();
      chk("t2_bit_valid", bit_valid, 1'b1);
      chk("t2_ready", load_ready, (k == 8 || k == 16));
      tick();
    end
    mid();
    chk("t2_after_valid", bit_valid, 1'b0);

    // 3: LSB-first instance, 8'h0B
    tick();
    data_in_l = 8'h0B; load_valid_l = 1'b1; push_word(8'h0B, 1'b0);
    tick();
    load_valid_l = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      mid();
      s[8-k] = sdout_l;
      chk("t3_busy", busy_l, 1'b1);
      tick();
    end
    chk("t3_stream", s, 8'hD0);

    // 4: 8'h03 then 8'h40, 1101 spans the word boundary
    tick();
    data_in = 8'h03; load_valid = 1'b1; push_word(8'h03, 1'b1);
    tick();
    data_in = 8'h40; push_word(8'h40, 1'b1);
    for (int k = 1; k <= 16; k++) begin
      if (k == 9) load_valid = 1'b0;
      mid();
      chk("t4_det", det, (k == 11));
      tick();
    end

    // 5: clr pulsed during cycle 4 of 8'hFF
    tick();
    data_in = 8'hFF; load_valid = 1'b1; push_word(8'hFF, 1'b1);
    tick();
    load_valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      mid();
      tick();
    end
    #1;
    clr = 1'b0;
    q_m.delete();
    load_valid = 1'b1; data_in = 8'h81;
    #1;
    chk("t5_sdout", sdout, 1'b0);
    chk("t5_busy", busy, 1'b0);
    chk("t5_bit_valid", bit_valid, 1'b0);
    chk("t5_ready_in_rst", load_ready, 1'b0);
    tick(); tick();
    load_valid = 1'b0;
    clr = 1'b1;
    mid();
    chk("t5_ready_after", load_ready, 1'b1);
    tick(); tick(); tick();
    mid();
    chk("t5_busy_after", busy, 1'b0);

    // 6: load_valid/data_in churn mid-word, chained word only at last bit
    tick();
    data_in = 8'hA5; load_valid = 1'b1; push_word(8'hA5, 1'b1);
    tick();
    for (int k = 1; k <= 8; k++) begin
      if (k < 8) begin
        load_valid = k[0];
        data_in    = 8'($urandom);
      end else begin
        load_valid = 1'b1;
        data_in    = 8'h3C;
        push_word(8'h3C, 1'b1);
      end
      mid();
      chk("t6_ready", load_ready, (k == 8));
      tick();
    end
    load_valid = 1'b0; data_in = 8'hE7;
    for (int k = 1; k <= 8; k++) begin
      mid();
      chk("t6_busy", busy, 1'b1);
      tick();
    end
    mid();
    chk("t6_idle", busy, 1'b0);

    tick(); tick();
    chk("end_q_m", q_m.size(), 0);
    chk("end_q_l", q_l.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
